// File: rtl/generic_bus_arbiter.sv
// rtl/generic_bus_arbiter.sv - round-robin arbiter sharing one GenericBus subordinate port between managers
module generic_bus_arbiter #(
    parameter int NumMgrs   = 2,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int ProtWidth = 4
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [NumMgrs-1:0]             mgrWEn,
    input  logic [NumMgrs-1:0]             mgrREn,
    input  logic [NumMgrs*AddrWidth-1:0]   mgrAddr,
    input  logic [NumMgrs*DataWidth-1:0]   mgrWData,
    input  logic [NumMgrs*DataWidth/8-1:0] mgrWStrb,
    input  logic [NumMgrs-1:0]             mgrIsBurst,
    input  logic [NumMgrs*2-1:0]           mgrBurstType,
    input  logic [NumMgrs*8-1:0]           mgrBurstLen,
    input  logic [NumMgrs-1:0]             mgrNonSec,
    input  logic [NumMgrs*ProtWidth-1:0]   mgrProt,
    output logic [NumMgrs*DataWidth-1:0]   mgrRData,
    output logic [NumMgrs-1:0]             mgrBusy,
    output logic [NumMgrs-1:0]             mgrError,

    output logic                           subWEn,
    output logic                           subREn,
    output logic [AddrWidth-1:0]           subAddr,
    output logic [DataWidth-1:0]           subWData,
    output logic [DataWidth/8-1:0]         subWStrb,
    output logic                           subIsBurst,
    output logic [1:0]                     subBurstType,
    output logic [7:0]                     subBurstLen,
    output logic                           subNonSec,
    output logic [ProtWidth-1:0]           subProt,
    input  logic [DataWidth-1:0]           subRData,
    input  logic                           subBusy,
    input  logic                           subError,

    output logic [NumMgrs-1:0]             grant
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int IdxW      = (NumMgrs > 1) ? $clog2(NumMgrs) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NumMgrs-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          beats_left_q, beats_left_d;

    logic [NumMgrs-1:0]  req;
    logic                owner_req;
    logic                beat_done;
    logic                arb_found;
    logic [IdxW-1:0]     arb_idx;
    logic                do_arb;

    assign req       = mgrWEn | mgrREn;
    // grant_q is all-zero in IDLE, so these are naturally false there
    assign owner_req = |(req & grant_q);
    assign beat_done = owner_req && !subBusy;
    assign grant     = grant_q;

    // Round-robin search: first requester found scanning upward from rr_ptr+1;
    // the previous winner sits at rr_ptr and is therefore checked last.
    always_comb begin
        int cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NumMgrs; k++) begin
            cand = (int'(rr_ptr_q) + k) % NumMgrs;
            if (!arb_found && req[IdxW'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IdxW'(cand);
            end
        end
    end

    // Forward the owner's vital and hint signals; everything is zero with no owner.
    always_comb begin
        subWEn       = 1'b0;
        subREn       = 1'b0;
        subAddr      = '0;
        subWData     = '0;
        subWStrb     = '0;
        subIsBurst   = 1'b0;
        subBurstType = '0;
        subBurstLen  = '0;
        subNonSec    = 1'b0;
        subProt      = '0;
        for (int i = 0; i < NumMgrs; i++) begin
            if (grant_q[i]) begin
                subWEn       = mgrWEn[i];
                subREn       = mgrREn[i];
                subAddr      = mgrAddr[i*AddrWidth +: AddrWidth];
                subWData     = mgrWData[i*DataWidth +: DataWidth];
                subWStrb     = mgrWStrb[i*StrbWidth +: StrbWidth];
                subIsBurst   = mgrIsBurst[i];
                subBurstType = mgrBurstType[i*2 +: 2];
                subBurstLen  = mgrBurstLen[i*8 +: 8];
                subNonSec    = mgrNonSec[i];
                subProt      = mgrProt[i*ProtWidth +: ProtWidth];
            end
        end
    end

    // Return path: owner sees the subordinate directly, waiting requesters are stalled.
    always_comb begin
        mgrRData = '0;
        mgrBusy  = '0;
        mgrError = '0;
        for (int i = 0; i < NumMgrs; i++) begin
            if (grant_q[i]) begin
                mgrRData[i*DataWidth +: DataWidth] = subRData;
                mgrBusy[i]                         = subBusy;
                mgrError[i]                        = subError;
            end else begin
                mgrBusy[i] = req[i];
            end
        end
    end

    // Next-state logic: ownership, burst lock and hand-over in the releasing cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        do_arb       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_arb = 1'b1;
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    do_arb = 1'b1;
                end else if (beat_done) begin
                    if (subIsBurst && (subBurstLen != 8'd0)) begin
                        // First beat done; subBurstLen more beats follow under lock
                        state_d      = ST_LOCKED;
                        beats_left_d = subBurstLen;
                    end else begin
                        do_arb = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // A dropped request only stalls the burst, it never releases it
                if (beat_done) begin
                    if (subError || (beats_left_q == 8'd1)) begin
                        do_arb = 1'b1;
                    end else begin
                        beats_left_d = beats_left_q - 8'd1;
                    end
                end
            end
            default: begin
                do_arb = 1'b1;
            end
        endcase

        if (do_arb) begin
            beats_left_d = 8'd0;
            if (arb_found) begin
                state_d          = ST_OWNED;
                grant_d          = '0;
                grant_d[arb_idx] = 1'b1;
                rr_ptr_d         = arb_idx;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end
    end

    // State registers; reset leaves the pointer on the last manager so manager 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= IdxW'(NumMgrs - 1);
            beats_left_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// tb/tb_generic_bus_arbiter.sv - directed self-checking bench for generic_bus_arbiter
module tb_generic_bus_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int PW = 4;

    logic              clk;
    logic              reset;
    logic [N-1:0]      mgrWEn, mgrREn, mgrIsBurst, mgrNonSec;
    logic [N*AW-1:0]   mgrAddr;
    logic [N*DW-1:0]   mgrWData;
    logic [N*DW/8-1:0] mgrWStrb;
    logic [N*2-1:0]    mgrBurstType;
    logic [N*8-1:0]    mgrBurstLen;
    logic [N*PW-1:0]   mgrProt;
    logic [N*DW-1:0]   mgrRData;
    logic [N-1:0]      mgrBusy, mgrError;
    logic              subWEn, subREn, subIsBurst, subNonSec;
    logic [AW-1:0]     subAddr;
    logic [DW-1:0]     subWData;
    logic [DW/8-1:0]   subWStrb;
    logic [1:0]        subBurstType;
    logic [7:0]        subBurstLen;
    logic [PW-1:0]     subProt;
    logic [DW-1:0]     subRData;
    logic              subBusy, subError;
    logic [N-1:0]      grant;

    int checks;
    int failures;

    localparam logic [31:0] ADDR0 = 32'h1000_0040;
    localparam logic [31:0] ADDR1 = 32'h2000_0080;
    localparam logic [31:0] RDATA = 32'hCAFE_F00D;

    generic_bus_arbiter #(
        .NumMgrs(N), .DataWidth(DW), .AddrWidth(AW), .ProtWidth(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .mgrWEn(mgrWEn), .mgrREn(mgrREn), .mgrAddr(mgrAddr), .mgrWData(mgrWData),
        .mgrWStrb(mgrWStrb), .mgrIsBurst(mgrIsBurst), .mgrBurstType(mgrBurstType),
        .mgrBurstLen(mgrBurstLen), .mgrNonSec(mgrNonSec), .mgrProt(mgrProt),
        .mgrRData(mgrRData), .mgrBusy(mgrBusy), .mgrError(mgrError),
        .subWEn(subWEn), .subREn(subREn), .subAddr(subAddr), .subWData(subWData),
        .subWStrb(subWStrb), .subIsBurst(subIsBurst), .subBurstType(subBurstType),
        .subBurstLen(subBurstLen), .subNonSec(subNonSec), .subProt(subProt),
        .subRData(subRData), .subBusy(subBusy), .subError(subError),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mgr(input int i, input logic wen, input logic ren,
                             input logic [31:0] addr, input logic burst, input logic [7:0] len);
        mgrWEn[i]                = wen;
        mgrREn[i]                = ren;
        mgrAddr[i*AW +: AW]      = addr;
        mgrWData[i*DW +: DW]     = addr ^ 32'h5A5A_5A5A;
        mgrWStrb[i*4 +: 4]       = 4'hF;
        mgrIsBurst[i]            = burst;
        mgrBurstLen[i*8 +: 8]    = len;
        mgrBurstType[i*2 +: 2]   = burst ? 2'b01 : 2'b00;
        mgrProt[i*PW +: PW]      = 4'(i + 1);
        mgrNonSec[i]             = 1'b1;
    endtask

    task automatic idle_all;
        mgrWEn = '0; mgrREn = '0; mgrIsBurst = '0; mgrBurstLen = '0;
        subBusy = 1'b0; subError = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_mgr(1, 1'b0, 1'b1, ADDR1, 1'b0, 8'd0);
        tick;
        tick;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (subREn !== 1'b0 || subAddr !== 32'h0) begin failures++; $display("FAIL reset_sub got ren=%b addr=%h exp 0", subREn, subAddr); end
        checks++; if (mgrBusy !== 2'b10) begin failures++; $display("FAIL reset_busy_follows_req got=%b exp=10", mgrBusy); end
        checks++; if (mgrRData !== '0 || mgrError !== 2'b00) begin failures++; $display("FAIL reset_returns got rdata=%h err=%b exp 0", mgrRData, mgrError); end
        drive_mgr(1, 1'b0, 1'b0, ADDR1, 1'b0, 8'd0);
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single_read;
        drive_mgr(0, 1'b0, 1'b1, ADDR0, 1'b0, 8'd0);
        #1;
        checks++; if (mgrBusy[0] !== 1'b1 || subREn !== 1'b0) begin failures++; $display("FAIL single_wait got busy0=%b subREn=%b exp 1/0", mgrBusy[0], subREn); end
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant); end
        checks++; if (subREn !== 1'b1 || subAddr !== ADDR0) begin failures++; $display("FAIL single_fwd got ren=%b addr=%h exp 1/%h", subREn, subAddr, ADDR0); end
        checks++; if (mgrBusy[0] !== 1'b0 || mgrRData[31:0] !== RDATA || mgrRData[63:32] !== 32'h0) begin failures++; $display("FAIL single_return got busy0=%b rdata=%h exp 0/%h", mgrBusy[0], mgrRData, RDATA); end
        checks++; if (subProt !== 4'd1 || subWStrb !== 4'hF) begin failures++; $display("FAIL single_hints got prot=%h strb=%h exp 1/f", subProt, subWStrb); end
        tick;
        drive_mgr(0, 1'b0, 1'b0, ADDR0, 1'b0, 8'd0);
        #1;
        checks++; if (subREn !== 1'b0) begin failures++; $display("FAIL single_drop_mirror got subREn=%b exp=0", subREn); end
        tick;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL single_release got=%b exp=00", grant); end
    endtask

    task automatic test_alternate;
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        drive_mgr(0, 1'b1, 1'b0, ADDR0, 1'b0, 8'd0);
        drive_mgr(1, 1'b1, 1'b0, ADDR1, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            tick;
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_a = (k % 2 == 0) ? ADDR1 : ADDR0;
            checks++; if (grant !== exp_g) begin failures++; $display("FAIL alt_grant[%0d] got=%b exp=%b", k, grant, exp_g); end
            checks++; if (subAddr !== exp_a || subWEn !== 1'b1) begin failures++; $display("FAIL alt_fwd[%0d] got addr=%h wen=%b exp %h/1", k, subAddr, subWEn, exp_a); end
        end
        mgrWEn = '0;
        tick;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL alt_idle got=%b exp=00", grant); end
    endtask

    task automatic test_burst_lock;
        drive_mgr(0, 1'b0, 1'b1, ADDR0, 1'b0, 8'd0);
        drive_mgr(1, 1'b1, 1'b0, ADDR1, 1'b1, 8'd3);
        #1;
        checks++; if (mgrBusy !== 2'b11) begin failures++; $display("FAIL burst_pre_busy got=%b exp=11", mgrBusy); end
        for (int b = 1; b <= 4; b++) begin
            tick;
            checks++; if (grant !== 2'b10) begin failures++; $display("FAIL burst_beat%0d_grant got=%b exp=10", b, grant); end
            checks++; if (mgrBusy[0] !== 1'b1 || subIsBurst !== 1'b1 || subBurstLen !== 8'd3) begin failures++; $display("FAIL burst_beat%0d_fwd got busy0=%b burst=%b len=%0d exp 1/1/3", b, mgrBusy[0], subIsBurst, subBurstLen); end
        end
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL burst_handover got=%b exp=01", grant); end
        checks++; if (subREn !== 1'b1 || subAddr !== ADDR0) begin failures++; $display("FAIL burst_handover_fwd got ren=%b addr=%h exp 1/%h", subREn, subAddr, ADDR0); end
    endtask

    task automatic test_sub_busy;
        drive_mgr(1, 1'b0, 1'b0, ADDR1, 1'b0, 8'd0);
        subBusy = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) tick;
            checks++; if (grant !== 2'b01) begin failures++; $display("FAIL busy_hold[%0d] got=%b exp=01", c, grant); end
            checks++; if (mgrBusy !== 2'b01) begin failures++; $display("FAIL busy_follow[%0d] got=%b exp=01", c, mgrBusy); end
        end
        tick;
        subBusy = 1'b0;
        #1;
        checks++; if (grant !== 2'b01 || mgrBusy[0] !== 1'b0) begin failures++; $display("FAIL busy_clear got grant=%b busy0=%b exp 01/0", grant, mgrBusy[0]); end
        idle_all;
    endtask

    task automatic test_error_abort;
        drive_mgr(0, 1'b1, 1'b0, ADDR0, 1'b1, 8'd5);
        tick;
        drive_mgr(1, 1'b0, 1'b1, ADDR1, 1'b0, 8'd0);
        #1;
        checks++; if (grant !== 2'b01 || mgrBusy[1] !== 1'b1) begin failures++; $display("FAIL err_beat1 got grant=%b busy1=%b exp 01/1", grant, mgrBusy[1]); end
        tick;
        subError = 1'b1;
        #1;
        checks++; if (grant !== 2'b01 || mgrError !== 2'b01) begin failures++; $display("FAIL err_beat2 got grant=%b err=%b exp 01/01", grant, mgrError); end
        tick;
        subError = 1'b0;
        #1;
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL err_release got=%b exp=10", grant); end
        checks++; if (mgrBusy[0] !== 1'b1 || subREn !== 1'b1) begin failures++; $display("FAIL err_waiter_fwd got busy0=%b ren=%b exp 1/1", mgrBusy[0], subREn); end
        idle_all;
    endtask

    task automatic test_reset_mid_burst;
        drive_mgr(1, 1'b1, 1'b0, ADDR1, 1'b1, 8'd4);
        tick;
        drive_mgr(0, 1'b0, 1'b1, ADDR0, 1'b0, 8'd0);
        tick;
        #1;
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rst_burst_owner got=%b exp=10", grant); end
        reset = 1'b1;
        tick;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_burst_grant got=%b exp=00", grant); end
        checks++; if (subWEn !== 1'b0 || subAddr !== 32'h0 || subIsBurst !== 1'b0 || subBurstLen !== 8'd0 || subWData !== 32'h0) begin failures++; $display("FAIL rst_burst_sub got wen=%b addr=%h burst=%b len=%0d exp all 0", subWEn, subAddr, subIsBurst, subBurstLen); end
        checks++; if (mgrBusy !== 2'b11) begin failures++; $display("FAIL rst_burst_busy got=%b exp=11", mgrBusy); end
        reset = 1'b0;
        tick;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rst_first_winner got=%b exp=01", grant); end
        idle_all;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        mgrWEn = '0; mgrREn = '0; mgrAddr = '0; mgrWData = '0; mgrWStrb = '0;
        mgrIsBurst = '0; mgrBurstType = '0; mgrBurstLen = '0; mgrNonSec = '0; mgrProt = '0;
        subRData = RDATA; subBusy = 1'b0; subError = 1'b0;

        test_reset;
        test_single_read;
        test_alternate;
        test_burst_lock;
        test_sub_busy;
        test_error_abort;
        test_reset_mid_burst;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/generic_bus_arbiter.md
# generic_bus_arbiter

Round-robin arbiter that shares one GenericBus subordinate port between `NumMgrs` managers. It sits between several bus managers (core fetch, load/store, DMA) and a single subordinate such as a memory or peripheral bridge. It forwards the granted manager's vital and hint signals to the subordinate, holds every other manager off with `busy`, and locks the grant for the full length of a burst.

## Interface
- `NumMgrs`, 2: number of managers; legal range 2–8.
- `DataWidth`, 32: data bus width in bits; must be a multiple of 8.
- `AddrWidth`, 32: address width in bits.
- `ProtWidth`, 4: width of the `prot` signal.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `mgrWEn`, `mgrREn`  in  NumMgrs: per-manager write and read requests; bit i belongs to manager i.
- `mgrAddr`  in  NumMgrs*AddrWidth: packed addresses; manager i occupies slice [i*AddrWidth +: AddrWidth]. The other per-manager vectors pack the same way.
- `mgrWData`  in  NumMgrs*DataWidth: write data.
- `mgrWStrb`  in  NumMgrs*DataWidth/8: write strobes.
- `mgrIsBurst`, `mgrNonSec`  in  NumMgrs: burst and non-secure hints.
- `mgrBurstType`  in  NumMgrs*2: burst type hint.
- `mgrBurstLen`  in  NumMgrs*8: burst length hint.
- `mgrProt`  in  NumMgrs*ProtWidth: protection hint.
- `mgrRData`  out  NumMgrs*DataWidth: read data returned to each manager.
- `mgrBusy`, `mgrError`  out  NumMgrs: stall and error returned to each manager.
- `subWEn`, `subREn`, `subAddr`, `subWData`, `subWStrb`, `subIsBurst`, `subBurstType`, `subBurstLen`, `subNonSec`, `subProt`  out: the granted manager's signals forwarded to the subordinate. Widths match one manager slice.
- `subRData`  in  DataWidth, `subBusy`  in  1, `subError`  in  1: the subordinate's responses.
- `grant`  out  NumMgrs: registered one-hot owner indication; all zeros when no manager owns the bus.

## Operation
- Manager i requests the bus when `req[i]` = `mgrWEn[i] | mgrREn[i]`.
- A beat completes in any cycle where an owner exists, the owner's request is high, and `subBusy` = 0.
- States:
  - IDLE: no owner. All sub outputs are 0.
  - OWNED: `grant` is one-hot. Sub outputs mirror the owner's slice combinationally.
  - LOCKED: same forwarding as OWNED, and a burst is in progress.
- Arbitration is evaluated in IDLE, and in OWNED or LOCKED whenever the owner releases.
  - The winner is the first requester scanning upward from `rrPtr+1` modulo NumMgrs.
  - `grant` and `rrPtr` take the winner at the next edge.
  - With no requesters, the next state is IDLE.
- OWNED:
  - Completed beat with `mgrIsBurst` = 1 and `mgrBurstLen` = L > 0: go to LOCKED with `beatsLeft` = L. A burst is L+1 beats in total.
  - Completed beat with `mgrIsBurst` = 0, or with L = 0: release.
  - Owner request low: release.
- LOCKED:
  - The owner is never released because its request is low.
  - Each completed beat decrements `beatsLeft`. A completed beat with `beatsLeft` = 1 releases.
  - A completed beat with `subError` = 1 releases immediately; the burst is aborted.
- On release, the next owner is chosen in the same cycle and takes the bus at the next edge. The releasing owner has the lowest priority in that arbitration.
- Returns to managers:
  - Owner: `mgrRData` = `subRData`, `mgrBusy` = `subBusy`, `mgrError` = `subError`.
  - Non-owner with its request high: `mgrBusy` = 1, `mgrError` = 0, `mgrRData` = 0.
  - Non-owner with its request low: all returns 0.
- `beatsLeft` is 8 bits. It never underflows, because release happens when it reaches 1.

## Timing
- Reset values: state IDLE, `grant` = 0, `rrPtr` = NumMgrs-1 (so manager 0 wins first), `beatsLeft` = 0.
- Every sub output is 0 while in IDLE. Every manager output is 0 except `mgrBusy[i]` = `req[i]`.
- Reset asserted mid-burst wins over all other activity: the next edge gives IDLE with `grant` = 0.
- Arbitration latency is 1 cycle: a request at cycle N in IDLE appears on the sub port at N+1. The manager sees `mgrBusy` = 1 at cycle N.
- Hand-over has no dead cycle: the owner's final beat completes at cycle N, and the new owner drives the sub port at N+1.
- The return paths (`subRData`, `subBusy`, `subError` to the manager outputs) are combinational, with no added latency.
- Managers hold their request and payload stable while `mgrBusy` = 1. The arbiter does not latch the payload.

## Test plan
- Reset, then manager 0 issues a single read at cycle 2 with `subBusy` = 0:
  - `grant` = 01 at cycle 3, and `subREn` = 1 at cycle 3.
  - `grant` returns to 00 at cycle 4 after manager 0 drops its request.
- Managers 0 and 1 request continuously with single beats and `subBusy` = 0: `grant` alternates 01, 10, 01, 10 every cycle with no gaps.
- Manager 1 issues a burst with `burstLen` = 3 while manager 0 requests:
  - Manager 1 holds `grant` for exactly 4 completed beats.
  - `mgrBusy[0]` = 1 throughout.
  - Manager 0 is granted the cycle after beat 4 completes.
- `subBusy` is held at 1 for 3 cycles during manager 0's beat: `grant` is unchanged, and `mgrBusy[0]` follows `subBusy`.
- `subError` = 1 on beat 2 of a `burstLen` = 5 burst: the owner is released, and a waiting manager is granted the next cycle.
- `reset` is asserted during beat 2 of a burst: at the next edge `grant` = 0, all sub outputs are 0, and manager 0 wins the first arbitration after reset.
